// File: rtl/armleocpu_tlb.sv
// Direct-mapped Sv32 TLB sitting between a cache and armleocpu_ptw.
// Misses are refilled from the page-table walker; faulting walks are never cached.
module armleocpu_tlb #(
    parameter int ENTRIES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [19:0] req_vpn,
    output logic        resp_valid,
    output logic [21:0] resp_ppn,
    output logic [7:0]  resp_access_bits,
    output logic        resp_pagefault,
    output logic        resp_accessfault,
    input  logic        invalidate,
    input  logic        matp_mode,
    output logic        ptw_resolve_request,
    input  logic        ptw_resolve_ack,
    output logic [19:0] ptw_virtual_address,
    input  logic        ptw_resolve_done,
    input  logic        ptw_resolve_pagefault,
    input  logic        ptw_resolve_accessfault,
    input  logic [7:0]  ptw_resolve_access_bits,
    input  logic [21:0] ptw_resolve_physical_address
);
    localparam int IDX = $clog2(ENTRIES);
    localparam int TAG = 20 - IDX;

    typedef enum logic [1:0] {IDLE, LOOKUP, REFILL_REQ, REFILL_WAIT} state_t;

    state_t             state;
    logic [19:0]        saved_vpn;
    logic [ENTRIES-1:0] valid;
    logic               drop;
    logic [TAG-1:0]     tag_mem  [ENTRIES];
    logic [21:0]        ppn_mem  [ENTRIES];
    logic [7:0]         bits_mem [ENTRIES];

    logic [IDX-1:0]     idx;
    logic [TAG-1:0]     saved_tag;
    logic               hit;
    logic               refill_write;

    assign idx       = saved_vpn[IDX-1:0];
    assign saved_tag = saved_vpn[19:IDX];
    assign req_ready = (state == IDLE);
    assign ptw_virtual_address = saved_vpn;

    // A same-cycle invalidate must win over both the lookup and the refill write.
    assign hit = valid[idx] && !invalidate && (tag_mem[idx] == saved_tag);
    assign refill_write = (state == REFILL_WAIT) && ptw_resolve_done
                          && !ptw_resolve_pagefault && !ptw_resolve_accessfault
                          && !drop && !invalidate;

    always_ff @(posedge clk) begin
        if (refill_write) begin
            tag_mem[idx]  <= saved_tag;
            ppn_mem[idx]  <= ptw_resolve_physical_address;
            bits_mem[idx] <= ptw_resolve_access_bits;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state               <= IDLE;
            saved_vpn           <= '0;
            valid               <= '0;
            drop                <= 1'b0;
            resp_valid          <= 1'b0;
            resp_ppn            <= '0;
            resp_access_bits    <= '0;
            resp_pagefault      <= 1'b0;
            resp_accessfault    <= 1'b0;
            ptw_resolve_request <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            if (invalidate)
                valid <= '0;
            else if (refill_write)
                valid[idx] <= 1'b1;

            case (state)
                IDLE: begin
                    drop <= 1'b0;
                    if (req_valid) begin
                        saved_vpn <= req_vpn;
                        if (matp_mode) begin
                            state <= LOOKUP;
                        end else begin
                            resp_valid       <= 1'b1;
                            resp_ppn         <= {2'b00, req_vpn};
                            resp_access_bits <= 8'hCF;
                            resp_pagefault   <= 1'b0;
                            resp_accessfault <= 1'b0;
                        end
                    end
                end
                LOOKUP: begin
                    if (hit) begin
                        resp_valid       <= 1'b1;
                        resp_ppn         <= ppn_mem[idx];
                        resp_access_bits <= bits_mem[idx];
                        resp_pagefault   <= 1'b0;
                        resp_accessfault <= 1'b0;
                        state            <= IDLE;
                    end else begin
                        ptw_resolve_request <= 1'b1;
                        state               <= REFILL_REQ;
                    end
                end
                REFILL_REQ: begin
                    if (invalidate)
                        drop <= 1'b1;
                    if (ptw_resolve_ack) begin
                        ptw_resolve_request <= 1'b0;
                        state               <= REFILL_WAIT;
                    end
                end
                REFILL_WAIT: begin
                    if (invalidate)
                        drop <= 1'b1;
                    if (ptw_resolve_done) begin
                        resp_valid       <= 1'b1;
                        resp_ppn         <= ptw_resolve_physical_address;
                        resp_access_bits <= ptw_resolve_access_bits;
                        resp_pagefault   <= ptw_resolve_pagefault;
                        resp_accessfault <= ptw_resolve_accessfault;
                        drop             <= 1'b0;
                        state            <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_armleocpu_tlb.sv
// Bench for armleocpu_tlb: vector table driven through a TLB/PTW model,
// responses checked against a queue of expected results.
module tb_armleocpu_tlb;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [19:0] req_vpn;
    logic        resp_valid;
    logic [21:0] resp_ppn;
    logic [7:0]  resp_access_bits;
    logic        resp_pagefault;
    logic        resp_accessfault;
    logic        invalidate;
    logic        matp_mode;
    logic        ptw_resolve_request;
    logic        ptw_resolve_ack;
    logic [19:0] ptw_virtual_address;
    logic        ptw_resolve_done;
    logic        ptw_resolve_pagefault;
    logic        ptw_resolve_accessfault;
    logic [7:0]  ptw_resolve_access_bits;
    logic [21:0] ptw_resolve_physical_address;

    armleocpu_tlb #(.ENTRIES(16)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_vpn(req_vpn),
        .resp_valid(resp_valid), .resp_ppn(resp_ppn),
        .resp_access_bits(resp_access_bits), .resp_pagefault(resp_pagefault),
        .resp_accessfault(resp_accessfault), .invalidate(invalidate),
        .matp_mode(matp_mode), .ptw_resolve_request(ptw_resolve_request),
        .ptw_resolve_ack(ptw_resolve_ack), .ptw_virtual_address(ptw_virtual_address),
        .ptw_resolve_done(ptw_resolve_done),
        .ptw_resolve_pagefault(ptw_resolve_pagefault),
        .ptw_resolve_accessfault(ptw_resolve_accessfault),
        .ptw_resolve_access_bits(ptw_resolve_access_bits),
        .ptw_resolve_physical_address(ptw_resolve_physical_address)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [19:0] vpn;
        logic        mode;
        logic        inv_before;
        logic [1:0]  inv_at;      // 1: during LOOKUP, 2: during REFILL_WAIT
        logic [21:0] ppn;
        logic [7:0]  bits;
        logic        pf;
        logic        af;
    } vec_t;

    int total = 0;
    int bad = 0;
    logic [31:0] expq[$];

    bit          m_valid [16];
    logic [19:0] m_vpn   [16];
    logic [21:0] m_ppn   [16];
    logic [7:0]  m_bits  [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    endtask

    always @(negedge clk) begin
        if (resp_valid) begin
            if (expq.size() == 0) begin
                chk("unexpected_resp", 32'd1, 32'd0);
            end else begin
                logic [31:0] e;
                e = expq.pop_front();
                chk("resp", {resp_ppn, resp_access_bits, resp_pagefault, resp_accessfault}, e);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_inv();
        invalidate = 1'b1;
        tick();
        invalidate = 1'b0;
        model_clear();
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 20 && !req_ready; i++) tick();
        chk("req_ready", {31'd0, req_ready}, 32'd1);
    endtask

    task automatic run(input vec_t v);
        int idx;
        bit miss;
        bit got;
        int n;
        int ph;
        int ptw_reqs;
        idx = int'(v.vpn[3:0]);
        if (v.inv_before) pulse_inv();
        if (v.inv_at == 2'd1) model_clear();
        miss = v.mode && !(m_valid[idx] && m_vpn[idx] == v.vpn);
        if (!v.mode)
            expq.push_back({2'b00, v.vpn, 8'hCF, 2'b00});
        else if (miss)
            expq.push_back({v.ppn, v.bits, v.pf, v.af});
        else
            expq.push_back({m_ppn[idx], m_bits[idx], 2'b00});

        ptw_resolve_physical_address = v.ppn;
        ptw_resolve_access_bits = v.bits;
        ptw_resolve_pagefault = v.pf;
        ptw_resolve_accessfault = v.af;
        wait_ready();
        req_vpn = v.vpn;
        matp_mode = v.mode;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        req_vpn = 20'($urandom);
        matp_mode = ~v.mode;

        got = 0; n = 0; ph = 0; ptw_reqs = 0;
        while (!got && n < 40) begin
            if (resp_valid) begin
                got = 1;
            end else begin
                ptw_resolve_ack = 1'b0;
                ptw_resolve_done = 1'b0;
                invalidate = 1'b0;
                if (v.inv_at == 2'd1 && n == 0) invalidate = 1'b1;
                if (ptw_resolve_request && ph == 0) begin
                    chk("ptw_va", {12'd0, ptw_virtual_address}, {12'd0, v.vpn});
                    ptw_resolve_ack = 1'b1;
                    ptw_reqs++;
                    ph = 1;
                end else if (ph == 1) begin
                    if (v.inv_at == 2'd2) invalidate = 1'b1;
                    ph = 2;
                end else if (ph == 2) begin
                    ptw_resolve_done = 1'b1;
                    ph = 3;
                end
                tick();
                n++;
            end
        end
        ptw_resolve_ack = 1'b0;
        ptw_resolve_done = 1'b0;
        invalidate = 1'b0;
        chk("resp_seen", {31'd0, got}, 32'd1);
        chk("ptw_req_count", ptw_reqs, {31'd0, miss});
        if (!miss) chk("latency", n, v.mode ? 32'd1 : 32'd0);
        tick();

        if (v.inv_at == 2'd2) begin
            model_clear();
        end else if (miss && !v.pf && !v.af) begin
            m_valid[idx] = 1'b1;
            m_vpn[idx] = v.vpn;
            m_ppn[idx] = v.ppn;
            m_bits[idx] = v.bits;
        end
    endtask

    function automatic vec_t mk(input logic [19:0] vpn, input logic mode, input logic ib,
                                input logic [1:0] ia, input logic [21:0] ppn,
                                input logic [7:0] bits, input logic pf, input logic af);
        vec_t v;
        v.vpn = vpn; v.mode = mode; v.inv_before = ib; v.inv_at = ia;
        v.ppn = ppn; v.bits = bits; v.pf = pf; v.af = af;
        return v;
    endfunction

    vec_t vecs[$];

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_vpn = '0; invalidate = 1'b0; matp_mode = 1'b1;
        ptw_resolve_ack = 1'b0; ptw_resolve_done = 1'b0; ptw_resolve_pagefault = 1'b0;
        ptw_resolve_accessfault = 1'b0; ptw_resolve_access_bits = '0;
        ptw_resolve_physical_address = '0;
        model_clear();

        vecs.push_back(mk(20'h12345, 1, 0, 0, 22'h0ABCD, 8'h0F, 0, 0));
        vecs.push_back(mk(20'h12345, 1, 0, 0, 22'h3FFFF, 8'h00, 0, 0));
        vecs.push_back(mk(20'h00007, 1, 0, 0, 22'h00011, 8'h01, 1, 0));
        vecs.push_back(mk(20'h00007, 1, 0, 0, 22'h00022, 8'h03, 0, 0));
        vecs.push_back(mk(20'h00008, 1, 0, 0, 22'h00033, 8'h05, 0, 1));
        vecs.push_back(mk(20'h00008, 1, 0, 0, 22'h00044, 8'h07, 0, 0));
        vecs.push_back(mk(20'h00003, 1, 0, 0, 22'h00100, 8'h0B, 0, 0));
        vecs.push_back(mk(20'h00013, 1, 0, 0, 22'h00200, 8'h0D, 0, 0));
        vecs.push_back(mk(20'h00003, 1, 0, 0, 22'h00101, 8'h0B, 0, 0));
        vecs.push_back(mk(20'h00001, 1, 0, 0, 22'h00055, 8'h1F, 0, 0));
        vecs.push_back(mk(20'h00001, 1, 0, 0, 22'h00000, 8'h00, 0, 0));
        vecs.push_back(mk(20'h00001, 1, 1, 0, 22'h00056, 8'h1F, 0, 0));
        vecs.push_back(mk(20'h00002, 1, 0, 2, 22'h00077, 8'hDF, 0, 0));
        vecs.push_back(mk(20'h00002, 1, 0, 0, 22'h00078, 8'hDF, 0, 0));
        vecs.push_back(mk(20'h00002, 1, 0, 0, 22'h00000, 8'h00, 0, 0));
        vecs.push_back(mk(20'hFFFFF, 0, 0, 0, 22'h12345, 8'h55, 0, 0));
        vecs.push_back(mk(20'h00002, 1, 0, 1, 22'h00079, 8'h4F, 0, 0));
        vecs.push_back(mk(20'h00002, 1, 0, 0, 22'h00000, 8'h00, 0, 0));

        repeat (3) tick();
        rst = 1'b0;
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_ptw_req", {31'd0, ptw_resolve_request}, 32'd0);
        chk("rst_resp_data", {resp_ppn, resp_access_bits, resp_pagefault, resp_accessfault}, 32'd0);

        foreach (vecs[i]) run(vecs[i]);

        // Reset while a walk is outstanding, then a stale PTW completion.
        begin
            bit seen;
            seen = 0;
            wait_ready();
            req_vpn = 20'h00009; matp_mode = 1'b1; req_valid = 1'b1;
            tick();
            req_valid = 1'b0;
            for (int i = 0; i < 10 && !seen; i++) begin
                if (ptw_resolve_request) seen = 1; else tick();
            end
            chk("rst_seq_ptw_req", {31'd0, seen}, 32'd1);
            ptw_resolve_ack = 1'b1;
            tick();
            ptw_resolve_ack = 1'b0;
            rst = 1'b1;
            tick();
            rst = 1'b0;
            model_clear();
            chk("midrst_ready", {31'd0, req_ready}, 32'd1);
            chk("midrst_resp_valid", {31'd0, resp_valid}, 32'd0);
            chk("midrst_ptw_req", {31'd0, ptw_resolve_request}, 32'd0);
            ptw_resolve_done = 1'b1;
            tick();
            ptw_resolve_done = 1'b0;
            chk("late_done_ignored", {31'd0, resp_valid}, 32'd0);
        end
        run(mk(20'h00002, 1, 0, 0, 22'h00088, 8'h0F, 0, 0));
        run(mk(20'h12345, 1, 0, 0, 22'h00099, 8'h0F, 0, 0));

        repeat (3) tick();
        chk("queue_empty", expq.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
